// File: rtl/plasma_pio_pkg.sv
// Shared definitions for the Plasma PIO slaves: Avalon word addresses and a
// constant-evaluable clog2 for sizing counters from parameters.
package plasma_pio_pkg;

    localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
    localparam logic [1:0] PIO_ADDR_DIR     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/plasma_debounce_bit.sv
// One input bit: SYNC_STAGES-deep synchroniser followed by a saturating
// stability counter that moves the debounced level only after a steady run.
module plasma_debounce_bit
    import plasma_pio_pkg::*;
#(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic RESET_LEVEL     = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic db_o
);

    localparam int             CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sample;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;

    assign sample = sync_q[SYNC_STAGES-1];
    assign db_o   = db_q;

    // NOTE: non-blocking assignments so every stage captures its neighbour's pre-edge value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
            cnt_q  <= '0;
            db_q   <= RESET_LEVEL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
            cnt_q  <= cnt_d;
            db_q   <= db_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sample != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/plasma_pio_in_debounce.sv
// Avalon-MM debounced input PIO with sticky edge capture and maskable irq.
// Define PLASMA_PIO_IN_BOTH_EDGES_EN to capture both edges instead of falling only.
module plasma_pio_in_debounce
    import plasma_pio_pkg::*;
#(
    parameter int               WIDTH           = 4,
    parameter int               SYNC_STAGES     = 2,
    parameter int               DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_LEVEL     = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_prev_q;
    logic [WIDTH-1:0] edges;
    logic [WIDTH-1:0] ec_clear;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             rd_en, wr_en;
    logic             unused_wdata;

    for (genvar g = 0; g < WIDTH; g++) begin : g_bit
        plasma_debounce_bit #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .RESET_LEVEL    (RESET_LEVEL[g])
        ) u_bit (
            .clk    (clk),
            .reset_n(reset_n),
            .in_i   (in_port[g]),
            .db_o   (db[g])
        );
    end

`ifdef PLASMA_PIO_IN_BOTH_EDGES_EN
    assign edges = db ^ db_prev_q;
`else
    assign edges = db_prev_q & ~db;
`endif

    assign rd_en        = chipselect && !read_n;
    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    always_comb begin
        irqmask_d = irqmask_q;
        ec_clear  = '0;
        if (wr_en && address == PIO_ADDR_IRQMASK) irqmask_d = writedata[WIDTH-1:0];
        if (wr_en && address == PIO_ADDR_EDGECAP) ec_clear  = writedata[WIDTH-1:0];
        // A new edge in the same cycle as its clear keeps the bit set.
        edgecap_d = (edgecap_q & ~ec_clear) | edges;
        irq_d     = |(edgecap_q & irqmask_q);

        // Reads see the pre-write register contents.
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                PIO_ADDR_DATA:    readdata_d = 32'(db);
                PIO_ADDR_IRQMASK: readdata_d = 32'(irqmask_q);
                PIO_ADDR_EDGECAP: readdata_d = 32'(edgecap_q);
                default:          readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_prev_q  <= RESET_LEVEL;
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            db_prev_q  <= db;
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_plasma_pio_in_debounce.sv
// Directed bench for plasma_pio_in_debounce with a window-based reference model
// compared on every falling clock edge, plus literal register-read expectations.
module tb_plasma_pio_in_debounce;

    localparam int W  = 4;
    localparam int SS = 2;
    localparam int DC = 4;
    localparam int HL = SS + DC - 1;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [W-1:0] in_port;
    logic        irq;

    int checks   = 0;
    int failures = 0;
    bit mon_en   = 1'b0;

    plasma_pio_in_debounce #(
        .WIDTH          (W),
        .SYNC_STAGES    (SS),
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (4'hF)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .read_n    (read_n),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw-sample history; a bit's debounced level flips once the
    // last DC synchronised samples all disagree with it.
    logic [HL-1:0][W-1:0] m_hist;
    logic [W-1:0]  m_db, m_prev, m_ec, m_mask;
    logic [31:0]   m_rd;
    logic          m_irq;

    function automatic logic [W-1:0] db_next(input logic [W-1:0] db, input logic [HL-1:0][W-1:0] hist);
        logic [W-1:0] n;
        n = db;
        for (int i = 0; i < W; i++) begin
            bit stable;
            stable = 1'b1;
            for (int j = SS - 1; j < HL; j++) begin
                if (hist[j][i] == db[i]) stable = 1'b0;
            end
            if (stable) n[i] = ~db[i];
        end
        return n;
    endfunction

    function automatic logic [W-1:0] edges_of(input logic [W-1:0] prev, input logic [W-1:0] cur);
`ifdef PLASMA_PIO_IN_BOTH_EDGES_EN
        return prev ^ cur;
`else
        return prev & ~cur;
`endif
    endfunction

    function automatic logic [31:0] reg_view(input logic [1:0] a, input logic [W-1:0] db,
                                             input logic [W-1:0] mask, input logic [W-1:0] ec);
        case (a)
            2'd0:    return 32'(db);
            2'd2:    return 32'(mask);
            2'd3:    return 32'(ec);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_hist <= {HL{4'hF}};
            m_db   <= 4'hF;
            m_prev <= 4'hF;
            m_ec   <= '0;
            m_mask <= '0;
            m_rd   <= '0;
            m_irq  <= 1'b0;
        end else begin
            m_hist <= {m_hist[HL-2:0], in_port};
            m_db   <= db_next(m_db, m_hist);
            m_prev <= m_db;
            m_ec   <= (m_ec & ~((chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : 4'h0))
                      | edges_of(m_prev, m_db);
            if (chipselect && !write_n && address == 2'd2) m_mask <= writedata[W-1:0];
            m_irq  <= |(m_ec & m_mask);
            if (chipselect && !read_n) m_rd <= reg_view(address, m_db, m_mask, m_ec);
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            check("cyc_readdata", readdata, m_rd);
            check("cyc_irq", 32'(irq), 32'(m_irq));
        end
    end

    task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
        chipselect = 1'b1;
        read_n     = 1'b0;
        address    = a;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        check(name, readdata, exp);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
        @(negedge clk);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 4'hF;

        // Reset state
        step(2);
        mon_en = 1'b1;
        step(1);
        check("rst_readdata", readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        bus_read(2'd0, 32'h0000_000F, "reset_data");
        bus_read(2'd2, 32'h0000_0000, "reset_irqmask");
        bus_read(2'd3, 32'h0000_0000, "reset_edgecap");
        check("reset_irq", 32'(irq), 32'h0);
        bus_write(2'd0, 32'h0000_0000);
        bus_write(2'd1, 32'hFFFF_FFFF);
        bus_read(2'd1, 32'h0000_0000, "reserved_reads_zero");
        bus_read(2'd0, 32'h0000_000F, "data_ignores_write");

        // Glitch of 3 cycles is rejected
        in_port = 4'hE;
        step(3);
        in_port = 4'hF;
        step(8);
        bus_read(2'd0, 32'h0000_000F, "glitch_data");
        bus_read(2'd3, 32'h0000_0000, "glitch_edgecap");

        // Held low: db changes 6 cycles after the input, capture one cycle later
        in_port = 4'hE;
        step(4);
        bus_read(2'd3, 32'h0000_0000, "edgecap_before_edge");
        bus_read(2'd0, 32'h0000_000F, "data_at_5_cycles");
        bus_read(2'd0, 32'h0000_000E, "data_at_6_cycles");
        check("model_db_pin", 32'(m_db), 32'h0000_000E);
        bus_read(2'd3, 32'h0000_0001, "edgecap_after_press");

        // Interrupt path
        bus_write(2'd2, 32'h0000_0001);
        check("irq_same_cycle_as_mask", 32'(irq), 32'h0);
        step(1);
        check("irq_after_mask", 32'(irq), 32'h1);
        bus_write(2'd3, 32'h0000_0000);
        step(1);
        check("irq_write_zero_no_clear", 32'(irq), 32'h1);
        bus_write(2'd3, 32'h0000_0001);
        check("irq_same_cycle_as_clear", 32'(irq), 32'h1);
        step(1);
        check("irq_after_clear", 32'(irq), 32'h0);
        bus_read(2'd3, 32'h0000_0000, "edgecap_cleared");
        bus_read(2'd2, 32'h0000_0001, "irqmask_readback");

        // Clear of bit 2 lands on the same edge that captures bit 2
        in_port = 4'hA;
        step(6);
        bus_write(2'd3, 32'h0000_0004);
        bus_read(2'd3, 32'h0000_0004, "edge_beats_clear");
        check("model_ec_pin", 32'(m_ec), 32'h0000_0004);
        bus_write(2'd3, 32'h0000_0004);
        bus_read(2'd3, 32'h0000_0000, "edgecap_bit2_cleared");

        // Rising edge on bit 0
        in_port = 4'hB;
        step(8);
        bus_read(2'd0, 32'h0000_000B, "data_after_release");
`ifdef PLASMA_PIO_IN_BOTH_EDGES_EN
        bus_read(2'd3, 32'h0000_0001, "rising_edge_captured");
`else
        bus_read(2'd3, 32'h0000_0000, "rising_edge_ignored");
`endif

        // Reset while bit 3 is mid-debounce (counter at 2)
        in_port = 4'h3;
        repeat (4) @(posedge clk);
        #2 reset_n = 1'b0;
        step(3);
        reset_n = 1'b1;
        bus_read(2'd0, 32'h0000_000F, "data_after_mid_reset");
        step(4);
        bus_read(2'd0, 32'h0000_000F, "restart_at_5_cycles");
        bus_read(2'd0, 32'h0000_0003, "restart_at_6_cycles");
        bus_read(2'd3, 32'h0000_000C, "edgecap_after_restart");
        check("model_ec_restart_pin", 32'(m_ec), 32'h0000_000C);
        check("irq_mask_was_reset", 32'(irq), 32'h0);

        // Read and write of IRQMASK in the same cycle
        chipselect = 1'b1;
        read_n     = 1'b0;
        write_n    = 1'b0;
        address    = 2'd2;
        writedata  = 32'h0000_0005;
        @(negedge clk);
        chipselect = 1'b0;
        read_n     = 1'b1;
        write_n    = 1'b1;
        check("rw_returns_old", readdata, 32'h0000_0000);
        bus_read(2'd2, 32'h0000_0005, "rw_write_applied");
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plasma_pio_in_debounce.md
Name: plasma_pio_in_debounce

Overview:
- Avalon-MM slave input port: the read-side counterpart of the 7-bit output PIOs that drive the HEX displays.
- Samples board pushbuttons and switches, synchronises and debounces them, and captures edges.
- Raises a maskable interrupt to the Plasma CPU.
- Sits on the same Avalon interconnect as the other PIO slaves, with a 2-bit word address.

Parameters:
- WIDTH, 4, number of input bits (1..32)
- SYNC_STAGES, 2, synchroniser flops per bit (>=2)
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before the debounced state changes (>=1)
- RESET_LEVEL, {WIDTH{1'b1}}, reset value of the synchroniser and debounced state (DE1-SoC keys idle high)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  2  Avalon word address
- chipselect  in  1  slave select
- read_n  in  1  active-low read strobe
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, registered
- in_port  in  WIDTH  raw asynchronous board inputs
- irq  out  1  level interrupt to CPU

Behaviour:
- Reset: asynchronous on reset_n, clock clk. While reset_n is low, all of the following hold:
  - sync chain = RESET_LEVEL
  - debounced state = RESET_LEVEL
  - all counters = 0
  - irqmask = 0
  - edgecapture = 0
  - readdata = 0
  - irq = 0
- A reset assertion mid-debounce or mid-read discards all in-progress state.
- Synchroniser: SYNC_STAGES flops per bit. The sampled value s[i] is the last stage.
- Debounce, per bit, independent:
  - Counter width is clog2(DEBOUNCE_CYCLES+1).
  - If s[i] == db[i], the counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1 and s[i] still differs, db[i] <= s[i] and the counter clears in the same cycle.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes db.
  - The counter saturates; it never wraps.
  - Latency from an in_port change to a db change is SYNC_STAGES + DEBOUNCE_CYCLES cycles.
- Edge detect: db_prev is registered db. An edge is flagged one cycle after db changes (see Optional Feature for which edges).
- Register map (32-bit, unused bits read 0):
  - 0 DATA, read-only: db. Writes are ignored.
  - 1 reserved: reads 0, writes ignored.
  - 2 IRQMASK, read/write: bits [WIDTH-1:0].
  - 3 EDGECAPTURE: sticky per bit; a write of 1 clears the bit; a write of 0 has no effect.
- Edge vs clear, same bit, same cycle: the edge wins and the bit stays 1.
- Read timing:
  - Read latency is fixed at 1, with no wait states.
  - readdata is registered on the cycle where chipselect && !read_n, and is valid the following cycle.
  - readdata holds its value otherwise.
- Write timing: a write takes effect on the clock edge where chipselect && !write_n.
- Simultaneous read and write asserted together: the write is performed and the read returns the pre-write value.
- irq is registered: irq <= |(edgecapture & irqmask).
  - It asserts 1 cycle after the capture bit sets, or 1 cycle after the mask write.
  - It deasserts 1 cycle after the clear.

Optional Feature:
- Macro: PLASMA_PIO_IN_BOTH_EDGES_EN.
- Defined: capture on any db transition (db ^ db_prev).
- Undefined: capture only on the falling edge (db_prev & ~db), i.e. a key press on active-low keys. Rising edges are never captured.
- The register map is unchanged in both builds.

Decomposition:
- Shared package plasma_pio_pkg:
  - address constants PIO_ADDR_DATA=2'd0, PIO_ADDR_DIR=2'd1, PIO_ADDR_IRQMASK=2'd2, PIO_ADDR_EDGECAP=2'd3
  - clog2 helper function
- One sub-module: plasma_debounce_bit. It contains the synchroniser, counter and db flop for a single bit, and is instantiated WIDTH times via generate.
- Register file, edge detect and Avalon decode stay in the top level.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
1. Reset values: hold reset_n low, then release; read addr 0, 2 and 3 -> 0x0000000F, 0x00000000, 0x00000000; irq=0.
2. Glitch rejection: pulse in_port[0] low for 3 cycles -> DATA stays 0xF, EDGECAPTURE stays 0. Hold it low for 10 cycles -> DATA reads 0xE exactly 6 cycles after the change, and EDGECAPTURE=0x1.
3. Interrupt path: write IRQMASK=0x1 after the capture -> irq asserts 1 cycle later. Write EDGECAPTURE=0x1 -> irq drops 1 cycle later. Writing 0x0 instead leaves irq high.
4. Clear/edge collision: time the write-1-clear of bit 2 to coincide with a new bit-2 edge -> EDGECAPTURE bit 2 remains 1.
5. Feature check: release in_port[0] (rising edge) -> EDGECAPTURE bit 0 sets only when PLASMA_PIO_IN_BOTH_EDGES_EN is defined.
6. Reset mid-debounce: take in_port[3] low, then assert reset_n at count 2 -> after release DATA=0xF. The debounce restarts from 0 and needs a full 6 cycles.
